// File: rtl/booth_seq_pkg.sv
// Shared defaults, FSM state encoding and counter sizing for the Booth
// multiplier sequencer and its operand buffer.
package booth_seq_pkg;

  localparam int DEF_WIDTH       = 32;
  localparam int DEF_ITER_CYCLES = 31;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_e;

  // Counter must hold ITER_CYCLES itself; clamp so a degenerate value still gets one bit.
  function automatic int cnt_width(input int iters);
    return (iters < 1) ? 1 : $clog2(iters + 1);
  endfunction

endpackage

// File: rtl/booth_operand_buf.sv
// One-entry operand register in front of the multiplier FSM. A write is taken
// only while empty; a pop frees it unless a new write lands in the same cycle.
module booth_operand_buf
  import booth_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [WIDTH-1:0] wr_a_i,
  input  logic [WIDTH-1:0] wr_b_i,
  input  logic             pop_i,
  output logic             full_o,
  output logic [WIDTH-1:0] a_o,
  output logic [WIDTH-1:0] b_o
);

  logic             full_q, full_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             push;

  assign push = wr_valid_i && !full_q;

  // A write has priority over a pop so a refill in the same cycle is kept.
  always_comb begin
    full_d = full_q;
    a_d    = a_q;
    b_d    = b_q;
    if (push) begin
      full_d = 1'b1;
      a_d    = wr_a_i;
      b_d    = wr_b_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
    end else begin
      full_q <= full_d;
      a_q    <= a_d;
      b_q    <= b_d;
    end
  end

  assign wr_ready_o = !full_q;
  assign full_o     = full_q;
  assign a_o        = a_q;
  assign b_o        = b_q;

endmodule

// File: rtl/booth_mult_sequencer.sv
// Valid/ready front and back end for the iterative Booth multiplier core:
// loads the core, waits out its fixed latency and registers the product.
module booth_mult_sequencer
  import booth_seq_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ITER_CYCLES = DEF_ITER_CYCLES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  output logic               mul_load,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  input  logic [2*WIDTH-1:0] mul_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_result,
  output logic               busy
);

  localparam int               CNT_W    = cnt_width(ITER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITER_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mul_load_q, mul_load_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;
  logic               out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] out_result_q, out_result_d;

  logic               buf_full;
  logic [WIDTH-1:0]   buf_a;
  logic [WIDTH-1:0]   buf_b;
  logic               in_fire;
  logic               capture;

  booth_operand_buf #(
    .WIDTH(WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .wr_valid_i(in_valid),
    .wr_ready_o(in_ready),
    .wr_a_i    (in_a),
    .wr_b_i    (in_b),
    .pop_i     (state_q == LOAD),
    .full_o    (buf_full),
    .a_o       (buf_a),
    .b_o       (buf_b)
  );

  assign in_fire = in_valid && in_ready;
  assign capture = (state_q == CAPTURE) && (!out_valid_q || out_ready);

  // IDLE looks at the incoming write so LOAD follows acceptance with no bubble.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (buf_full || in_fire) state_d = LOAD;
      end
      LOAD: begin
        cnt_d   = CNT_INIT;
        state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q <= CNT_ONE) state_d = CAPTURE;
      end
      CAPTURE: begin
        if (capture) state_d = buf_full ? LOAD : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operands are registered on entry to LOAD so the core samples them with its load pulse.
  always_comb begin
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_load_d = (state_d == LOAD);
    if (state_d == LOAD) begin
      mul_a_d = buf_full ? buf_a : in_a;
      mul_b_d = buf_full ? buf_b : in_b;
    end
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_result_d = out_result_q;
    if (capture) begin
      out_valid_d  = 1'b1;
      out_result_d = mul_result;
    end else if (out_valid_q && out_ready) begin
      out_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      mul_load_q   <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      out_valid_q  <= 1'b0;
      out_result_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      mul_load_q   <= mul_load_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
      out_valid_q  <= out_valid_d;
      out_result_q <= out_result_d;
    end
  end

  assign mul_load   = mul_load_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign out_valid  = out_valid_q;
  assign out_result = out_result_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_booth_mult_sequencer.sv
// Bench for booth_mult_sequencer paired with a behavioural Booth core model of
// the same latency; a scoreboard queue tracks every accepted operand pair.
module tb_booth_mult_sequencer;

  localparam int W    = 32;
  localparam int ITER = 31;
  localparam int LAT  = ITER + 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic          mul_load;
  logic [W-1:0]  mul_a;
  logic [W-1:0]  mul_b;
  logic [63:0]   mul_result;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [63:0]   out_result;
  logic          busy;

  int nCompared = 0;
  int nMismatched = 0;
  int cyc = 0;
  logic [63:0] expQ[$];

  booth_mult_sequencer #(
    .WIDTH(W),
    .ITER_CYCLES(ITER)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .mul_load  (mul_load),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_result(mul_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_result(out_result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] signedProduct(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ea;
    logic [63:0] eb;
    ea = {{32{a[31]}}, a};
    eb = {{32{b[31]}}, b};
    return ea * eb;
  endfunction

  // Core model: load is its synchronous reset; junk until ITER iterations are done, then holds.
  logic [31:0] coreA = '0;
  logic [31:0] coreB = '0;
  int          coreCnt = 0;
  logic [63:0] coreRes = '0;

  always @(posedge clk) begin
    if (mul_load) begin
      coreA   <= mul_a;
      coreB   <= mul_b;
      coreCnt <= ITER;
      coreRes <= 64'hDEAD_BEEF_0000_0000;
    end else if (coreCnt != 0) begin
      coreCnt <= coreCnt - 1;
      coreRes <= (coreCnt == 1) ? signedProduct(coreA, coreB)
                                : (64'hDEAD_BEEF_0000_0000 | 64'(coreCnt));
    end
  end

  assign mul_result = coreRes;

  // Scoreboard sampled mid-cycle: handshakes seen here complete at the next rising edge.
  always @(negedge clk) begin
    if (reset) begin
      expQ.delete();
    end else begin
      if (out_valid && out_ready) begin
        nCompared++;
        if (expQ.size() == 0) begin
          nMismatched++;
          $display("[TB] FAIL sb_unexpected: out_result=%h popped with no pair outstanding", out_result);
        end else begin
          logic [63:0] expVal;
          expVal = expQ.pop_front();
          if (out_result !== expVal) begin
            nMismatched++;
            $display("[TB] FAIL sb_product: got %h expected %h", out_result, expVal);
          end
        end
      end
      if (in_valid && in_ready) expQ.push_back(signedProduct(in_a, in_b));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int c);
    while (cyc < c) tick();
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, output int tAcc);
    in_a = a;
    in_b = b;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !in_ready; k++) tick();
    if (!in_ready) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL offer_timeout: in_ready=%0b required 1", in_ready);
      tAcc = cyc;
      in_valid = 1'b0;
    end else begin
      tAcc = cyc;
      tick();
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 300 && (busy || out_valid); k++) tick();
    if (busy || out_valid) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL drain_timeout: busy=%0b out_valid=%0b required 0/0", busy, out_valid);
    end
  endtask

  task automatic test_reset();
    #2 reset = 1'b1;
    tick();
    tick();
    nCompared += 7;
    if (in_ready !== 1'b1)  begin nMismatched++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    if (mul_load !== 1'b0)  begin nMismatched++; $display("[TB] FAIL reset_mul_load: got %b expected 0", mul_load); end
    if (mul_a !== 32'h0)    begin nMismatched++; $display("[TB] FAIL reset_mul_a: got %h expected 0", mul_a); end
    if (mul_b !== 32'h0)    begin nMismatched++; $display("[TB] FAIL reset_mul_b: got %h expected 0", mul_b); end
    if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    if (out_result !== 64'h0) begin nMismatched++; $display("[TB] FAIL reset_out_result: got %h expected 0", out_result); end
    if (busy !== 1'b0)      begin nMismatched++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    tick();
    tick();
    nCompared += 2;
    if (busy !== 1'b0)     begin nMismatched++; $display("[TB] FAIL post_reset_busy: got %b expected 0", busy); end
    if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL post_reset_in_ready: got %b expected 1", in_ready); end
  endtask

  task automatic test_products();
    logic [31:0] tabA [4];
    logic [31:0] tabB [4];
    logic [63:0] tabP [4];
    int t;
    tabA[0] = 32'd3;         tabB[0] = 32'd5;         tabP[0] = 64'h0000_0000_0000_000F;
    tabA[1] = 32'hFFFF_FFF9; tabB[1] = 32'd6;         tabP[1] = 64'hFFFF_FFFF_FFFF_FFD6;
    tabA[2] = 32'h8000_0000; tabB[2] = 32'h8000_0000; tabP[2] = 64'h4000_0000_0000_0000;
    tabA[3] = 32'h7FFF_FFFF; tabB[3] = 32'h8000_0000; tabP[3] = 64'hC000_0000_8000_0000;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(tabA[i], tabB[i], t);
      nCompared += 4;
      if (mul_load !== 1'b1)  begin nMismatched++; $display("[TB] FAIL prod%0d_load: got %b expected 1", i, mul_load); end
      if (mul_a !== tabA[i])  begin nMismatched++; $display("[TB] FAIL prod%0d_mul_a: got %h expected %h", i, mul_a, tabA[i]); end
      if (mul_b !== tabB[i])  begin nMismatched++; $display("[TB] FAIL prod%0d_mul_b: got %h expected %h", i, mul_b, tabB[i]); end
      if (in_ready !== 1'b0)  begin nMismatched++; $display("[TB] FAIL prod%0d_in_ready: got %b expected 0", i, in_ready); end
      waitUntil(t + LAT - 1);
      nCompared++;
      if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL prod%0d_early: out_valid=%b expected 0", i, out_valid); end
      tick();
      nCompared += 2;
      if (out_valid !== 1'b1)   begin nMismatched++; $display("[TB] FAIL prod%0d_valid: got %b expected 1", i, out_valid); end
      if (out_result !== tabP[i]) begin nMismatched++; $display("[TB] FAIL prod%0d_result: got %h expected %h", i, out_result, tabP[i]); end
      tick();
      nCompared++;
      if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL prod%0d_pop: out_valid=%b expected 0", i, out_valid); end
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pa [3];
    logic [31:0] pb [3];
    int acc [4];
    int loads [4];
    int outs [4];
    int nAcc, nLoad, nOut, idx, t0;
    logic fireNow;
    pa[0] = 32'd11;        pb[0] = 32'hFFFF_FFFE;
    pa[1] = 32'hFFFE_7960; pb[1] = 32'h0004_93E0;
    pa[2] = 32'h1234_5678; pb[2] = 32'h9ABC_DEF0;
    nAcc = 0; nLoad = 0; nOut = 0; idx = 0;
    out_ready = 1'b1;
    in_a = pa[0];
    in_b = pb[0];
    in_valid = 1'b1;
    for (int k = 0; k < 110; k++) begin
      fireNow = in_valid && in_ready;
      if (fireNow && nAcc < 4) begin acc[nAcc] = cyc; nAcc++; end
      if (mul_load && nLoad < 4) begin loads[nLoad] = cyc; nLoad++; end
      if (out_valid && nOut < 4) begin outs[nOut] = cyc; nOut++; end
      tick();
      if (fireNow) begin
        idx++;
        if (idx < 3) begin in_a = pa[idx]; in_b = pb[idx]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    nCompared += 3;
    if (nAcc !== 3)  begin nMismatched++; $display("[TB] FAIL b2b_accepts: got %0d expected 3", nAcc); end
    if (nLoad !== 3) begin nMismatched++; $display("[TB] FAIL b2b_loads: got %0d expected 3", nLoad); end
    if (nOut !== 3)  begin nMismatched++; $display("[TB] FAIL b2b_outputs: got %0d expected 3", nOut); end
    if (nAcc == 3 && nLoad == 3 && nOut == 3) begin
      t0 = acc[0];
      nCompared += 8;
      if (acc[1] !== t0 + 2)         begin nMismatched++; $display("[TB] FAIL b2b_acc1: got T+%0d expected T+2", acc[1] - t0); end
      if (acc[2] !== t0 + 35)        begin nMismatched++; $display("[TB] FAIL b2b_acc2: got T+%0d expected T+35", acc[2] - t0); end
      if (loads[0] !== t0 + 1)       begin nMismatched++; $display("[TB] FAIL b2b_load0: got T+%0d expected T+1", loads[0] - t0); end
      if (loads[1] !== loads[0] + 33) begin nMismatched++; $display("[TB] FAIL b2b_load1: gap %0d expected 33", loads[1] - loads[0]); end
      if (loads[2] !== loads[1] + 33) begin nMismatched++; $display("[TB] FAIL b2b_load2: gap %0d expected 33", loads[2] - loads[1]); end
      if (outs[0] !== t0 + LAT)      begin nMismatched++; $display("[TB] FAIL b2b_out0: got T+%0d expected T+%0d", outs[0] - t0, LAT); end
      if (outs[1] !== outs[0] + 33)  begin nMismatched++; $display("[TB] FAIL b2b_out1: gap %0d expected 33", outs[1] - outs[0]); end
      if (outs[2] !== outs[1] + 33)  begin nMismatched++; $display("[TB] FAIL b2b_out2: gap %0d expected 33", outs[2] - outs[1]); end
    end
    drain();
  endtask

  task automatic test_stall();
    int t, t2, bad;
    logic [63:0] prodA;
    logic [63:0] prodB;
    prodA = 64'hFFFF_FFFF_FFF0_BDC0;
    prodB = 64'h0000_0000_0000_0001;
    out_ready = 1'b0;
    applyStimulus(32'd1000, 32'hFFFF_FC18, t);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, t2);
    nCompared++;
    if (t2 !== t + 2) begin nMismatched++; $display("[TB] FAIL stall_second_accept: got T+%0d expected T+2", t2 - t); end
    waitUntil(t + LAT);
    nCompared += 2;
    if (out_valid !== 1'b1)   begin nMismatched++; $display("[TB] FAIL stall_first_valid: got %b expected 1", out_valid); end
    if (out_result !== prodA) begin nMismatched++; $display("[TB] FAIL stall_first_result: got %h expected %h", out_result, prodA); end
    bad = 0;
    while (cyc < t + 79) begin
      if (out_valid !== 1'b1 || out_result !== prodA) bad++;
      tick();
    end
    nCompared += 2;
    if (bad !== 0)     begin nMismatched++; $display("[TB] FAIL stall_hold: %0d disturbed cycles, expected 0", bad); end
    if (busy !== 1'b1) begin nMismatched++; $display("[TB] FAIL stall_busy: got %b expected 1", busy); end
    out_ready = 1'b1;
    tick();
    nCompared += 3;
    if (out_valid !== 1'b1)   begin nMismatched++; $display("[TB] FAIL stall_pop_capture_valid: got %b expected 1", out_valid); end
    if (out_result !== prodB) begin nMismatched++; $display("[TB] FAIL stall_second_result: got %h expected %h", out_result, prodB); end
    if (busy !== 1'b0)        begin nMismatched++; $display("[TB] FAIL stall_idle_after: busy=%b expected 0", busy); end
    tick();
    nCompared++;
    if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL stall_final_pop: out_valid=%b expected 0", out_valid); end
    drain();
  endtask

  task automatic test_reset_mid_run();
    int t, ghosts;
    out_ready = 1'b1;
    applyStimulus(32'd9, 32'd9, t);
    waitUntil(t + 23);
    #2 reset = 1'b1;
    #1;
    nCompared += 6;
    if (busy !== 1'b0)        begin nMismatched++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    if (mul_a !== 32'h0)      begin nMismatched++; $display("[TB] FAIL rst_mul_a: got %h expected 0", mul_a); end
    if (mul_b !== 32'h0)      begin nMismatched++; $display("[TB] FAIL rst_mul_b: got %h expected 0", mul_b); end
    if (in_ready !== 1'b1)    begin nMismatched++; $display("[TB] FAIL rst_in_ready: got %b expected 1", in_ready); end
    if (out_result !== 64'h0) begin nMismatched++; $display("[TB] FAIL rst_out_result: got %h expected 0", out_result); end
    if (mul_load !== 1'b0)    begin nMismatched++; $display("[TB] FAIL rst_mul_load: got %b expected 0", mul_load); end
    tick();
    tick();
    reset = 1'b0;
    ghosts = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) ghosts++;
      tick();
    end
    nCompared++;
    if (ghosts !== 0) begin nMismatched++; $display("[TB] FAIL rst_ghost_output: %0d active cycles, expected 0", ghosts); end
    applyStimulus(32'd4, 32'hFFFF_FFFD, t);
    waitUntil(t + LAT - 1);
    nCompared++;
    if (out_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL rst_new_early: out_valid=%b expected 0", out_valid); end
    tick();
    nCompared += 2;
    if (out_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL rst_new_valid: got %b expected 1", out_valid); end
    if (out_result !== 64'hFFFF_FFFF_FFFF_FFF4) begin nMismatched++; $display("[TB] FAIL rst_new_result: got %h expected fffffffffffffff4", out_result); end
    drain();
  endtask

  task automatic test_load_refill();
    int t;
    out_ready = 1'b1;
    in_a = 32'd21;
    in_b = 32'd2;
    in_valid = 1'b1;
    tick();
    t = cyc - 1;
    in_a = 32'hFFFF_FF00;
    in_b = 32'd3;
    nCompared += 3;
    if (mul_load !== 1'b1) begin nMismatched++; $display("[TB] FAIL refill_load: got %b expected 1", mul_load); end
    if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL refill_in_ready_load: got %b expected 0", in_ready); end
    if (mul_a !== 32'd21)  begin nMismatched++; $display("[TB] FAIL refill_mul_a_load: got %h expected 15", mul_a); end
    tick();
    nCompared++;
    if (in_ready !== 1'b1) begin nMismatched++; $display("[TB] FAIL refill_in_ready_free: got %b expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    waitUntil(t + 20);
    nCompared += 3;
    if (in_ready !== 1'b0) begin nMismatched++; $display("[TB] FAIL refill_buf_full: in_ready=%b expected 0", in_ready); end
    if (mul_a !== 32'd21)  begin nMismatched++; $display("[TB] FAIL refill_mul_a_run: got %h expected 15", mul_a); end
    if (mul_b !== 32'd2)   begin nMismatched++; $display("[TB] FAIL refill_mul_b_run: got %h expected 2", mul_b); end
    waitUntil(t + LAT);
    nCompared += 4;
    if (mul_load !== 1'b1)       begin nMismatched++; $display("[TB] FAIL refill_second_load: got %b expected 1", mul_load); end
    if (mul_a !== 32'hFFFF_FF00) begin nMismatched++; $display("[TB] FAIL refill_second_a: got %h expected ffffff00", mul_a); end
    if (mul_b !== 32'd3)         begin nMismatched++; $display("[TB] FAIL refill_second_b: got %h expected 3", mul_b); end
    if (out_result !== 64'd42)   begin nMismatched++; $display("[TB] FAIL refill_first_result: got %h expected 2a", out_result); end
    drain();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] starting booth_mult_sequencer bench");
    test_reset();
    test_products();
    test_back_to_back();
    test_stall();
    test_reset_mid_run();
    test_load_refill();
    nCompared++;
    if (expQ.size() !== 0) begin nMismatched++; $display("[TB] FAIL sb_leftover: %0d results never produced, expected 0", expQ.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/booth_mult_sequencer.md
# booth_mult_sequencer

Handshake front/back end for the iterative 32-bit Booth multiplier core. It accepts signed operand pairs over a valid/ready interface and buffers one pending pair. It drives the core's load pulse and operands, counts the fixed iteration latency, then captures the 64-bit product into an output register presented over valid/ready. It sits directly upstream and downstream of the core, which has no handshake of its own.

## Interface
- `WIDTH`, 32: operand width; product is 2*WIDTH.
- `ITER_CYCLES`, 31: core iterations after load until `mul_result` is final; the core holds its result afterwards.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `in_valid` in 1: operand pair offered.
- `in_ready` out 1: pending-operand buffer empty.
- `in_a` in WIDTH: multiplier operand, signed; routed to the core's `a`.
- `in_b` in WIDTH: multiplicand, signed; routed to the core's `b`.
- `mul_load` out 1: one-cycle load pulse, wired to the core's synchronous `reset`.
- `mul_a` out WIDTH: operand to the core, held stable from LOAD through CAPTURE.
- `mul_b` out WIDTH: operand to the core, held stable from LOAD through CAPTURE.
- `mul_result` in 2*WIDTH: core product.
- `out_valid` out 1: product register holds an unread result.
- `out_ready` in 1: consumer accepts the product.
- `out_result` out 2*WIDTH: signed product.
- `busy` out 1: FSM not in IDLE.

## Operation
- Pending buffer: one entry (`in_a`, `in_b`).
  - Written on `in_valid && in_ready`.
  - `in_ready = !buf_full`.
- FSM states and transitions:
  - IDLE: go to LOAD when `buf_full`.
  - LOAD: lasts 1 cycle.
    - Latch buffer contents into `mul_a`/`mul_b`.
    - Clear `buf_full`, unless a new write lands in the same cycle, in which case the buffer holds the new pair.
    - `mul_load = 1`.
    - Load the iteration counter with `ITER_CYCLES`.
  - RUN: decrement the counter each cycle; go to CAPTURE after `ITER_CYCLES` cycles.
  - CAPTURE: if `!out_valid`, or `out_ready` this cycle (pop), write `mul_result` to `out_result` and set `out_valid`. Then go to LOAD if `buf_full`, else IDLE. Otherwise stay in CAPTURE; the core holds its result.
- Output register:
  - `out_valid` clears on `out_valid && out_ready` unless a capture happens in the same cycle.
  - `out_result` is stable while `out_valid && !out_ready`.
- Width: `out_result` is the raw 2*WIDTH core value, with no sign manipulation in this block.
- Reset values: `in_ready = 1`, `mul_load = 0`, `mul_a = 0`, `mul_b = 0`, `out_valid = 0`, `out_result = 0`, `busy = 0`, state IDLE, counter 0, `buf_full = 0`.
- Reset mid-operation:
  - All state is dropped and no result is emitted.
  - The core's internal state is ignored; the next LOAD reinitialises it.

## Timing
- Pair accepted at cycle T with the FSM in IDLE:
  - LOAD at T+1.
  - RUN at T+2 through T+1+ITER_CYCLES.
  - CAPTURE at T+2+ITER_CYCLES.
  - `out_valid` high from T+3+ITER_CYCLES (T+34 at default).
- Throughput: one product per ITER_CYCLES+2 cycles (33 at default) with a full buffer and `out_ready` held high. The CAPTURE→LOAD path has no IDLE bubble.
- `mul_load` is registered; it is high exactly during LOAD.
- `in_ready` drops the cycle after acceptance and rises the cycle after LOAD, unless refilled.
- Combinational paths: only `out_ready` → capture/stall decision. There is no input-to-`in_ready` combinational path.

## Structure
- Package `booth_seq_pkg`:
  - `WIDTH` default.
  - `ITER_CYCLES` default.
  - State enum: IDLE, LOAD, RUN, CAPTURE.
  - Counter width `$clog2(ITER_CYCLES+1)`.
- Sub-module `booth_operand_buf`: one-entry valid/ready operand register holding `buf_full` and the data. The FSM, counter and output register stay in the top.

## Test plan
Bench pairs this block with the Booth core, or a behavioural model with identical ITER_CYCLES latency.
- 3 × 5 accepted at T, `out_ready = 1` → `out_valid` first at T+34, `out_result = 0x0000_0000_0000_000F`, `out_valid` low next cycle.
- −7 × 6 (`in_a = 0xFFFF_FFF9`, `in_b = 6`) → `out_result = 0xFFFF_FFFF_FFFF_FFD6`.
- Three pairs streamed with `in_valid` held high → `in_ready` pattern 1,0…, products 33 cycles apart, `mul_load` pulses exactly 33 cycles apart.
- `out_ready = 0` with two ops queued → second op stalls in CAPTURE. `out_result` is unchanged while stalled. Raising `out_ready` pops the first product and captures the second in the same cycle, so `out_valid` stays high.
- `reset` asserted mid-RUN (counter = 10), asynchronously off-edge → all outputs return to reset values immediately, with no `out_valid` afterward. A new pair then completes normally at T+34.
- `in_valid` and acceptance in the same cycle as LOAD → the buffer stays full with the new pair, and the following LOAD uses it.
